ram_reader: RTL and testbench

- Read-side counterpart of ramcontroller in the RC4 datapath.
- Given a base address and byte count, it issues sequential reads to the 256-byte S/working RAM.
- It absorbs the RAM read latency and streams the bytes out on a valid/ready interface to the downstream consumer (swap/keystream logic, debug dump).
- It uses the same level-held start / finished handshake as ramcontroller.

---
 rtl/rc4_pkg.sv | 15 +
 rtl/ram_reader_rd_fifo.sv | 55 +++++
 rtl/ram_reader.sv | 135 +++++++++++++
 tb/tb_ram_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 datapath definitions: bus widths, reader FSM states, byte type.
package rc4_pkg;

    localparam int RC4_ADDR_W = 8;
    localparam int RC4_DATA_W = 8;

    typedef logic [RC4_DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/ram_reader_rd_fifo.sv
// Small show-ahead FIFO used to absorb RAM read latency in ram_reader.
module rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Sequential RAM reader streaming bytes on valid/ready with start/finished handshake.
// Optional XOR checksum output enabled by defining RAM_READER_CHECKSUM_EN.
module ram_reader
    import rc4_pkg::*;
#(
    parameter int ADDR_W     = RC4_ADDR_W,
    parameter int DATA_W     = RC4_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              finished,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready
`ifdef RAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int DEPTH = RD_LATENCY + 1;
    localparam int LW    = $clog2(DEPTH+1);

    rd_state_e              state_q, state_d;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W:0]        count_q;
    logic [ADDR_W:0]        issued;
    logic [ADDR_W:0]        popped;
    logic [RD_LATENCY-1:0]  pipe;

    logic                   accept, abort, issue, pop, push, last_pop;
    logic [7:0]             occ;
    logic [DATA_W-1:0]      fifo_head;
    logic                   fifo_empty;
    logic [LW-1:0]          fifo_level;

    assign accept     = (state_q == RD_IDLE) && start;
    assign abort      = (state_q == RD_RUN) && !start;
    assign data_valid = (state_q == RD_RUN) && !fifo_empty;
    assign pop        = data_valid && data_ready;
    assign push       = (state_q == RD_RUN) && pipe[RD_LATENCY-1];
    assign last_pop   = pop && ((popped + (ADDR_W+1)'(1)) == count_q);

    assign finished = (state_q == RD_DONE);
    assign wren     = 1'b0;
    assign address  = base_q + issued[ADDR_W-1:0];
    assign data_out = fifo_head;

    // Credit: everything in flight plus everything buffered, less this cycle's pop,
    // must leave room so a new read can never overflow the FIFO.
    always_comb begin
        occ = 8'(fifo_level);
        for (int unsigned i = 0; i < RD_LATENCY; i++) occ = occ + 8'(pipe[i]);
        issue = (state_q == RD_RUN) && start && (issued < count_q)
                && ((occ - 8'(pop)) < 8'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (start) state_d = (count == '0) ? RD_DONE : RD_RUN;
            RD_RUN: begin
                if (!start)        state_d = RD_IDLE;
                else if (last_pop) state_d = RD_DONE;
            end
            RD_DONE: if (!start) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RD_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            count_q <= '0;
            issued  <= '0;
            popped  <= '0;
        end else if (accept) begin
            base_q  <= base_addr;
            count_q <= count;
            issued  <= '0;
            popped  <= '0;
        end else begin
            if (issue) issued <= issued + (ADDR_W+1)'(1);
            if (pop)   popped <= popped + (ADDR_W+1)'(1);
        end
    end

    // Outside an active job any read still in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if ((state_q != RD_RUN) || !start) begin
            pipe <= '0;
        end else begin
            pipe[0] <= issue;
            for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (ram_out),
        .pop       (pop),
        .flush     (abort),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef RAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              checksum <= '0;
        else if (accept || abort) checksum <= '0;
        else if (pop)            checksum <= checksum ^ fifo_head;
    end
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader against a RAM preloaded with S[i]=i.
// Checksum checks are compiled in when RAM_READER_CHECKSUM_EN is defined.
module tb_ram_reader;

    localparam int LAT   = 1;
    localparam int DEPTH = LAT + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] count;
    logic       finished;
    logic [7:0] address;
    logic       wren;
    logic [7:0] ram_out;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
`ifdef RAM_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    ram_reader #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .RD_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .finished   (finished),
        .address    (address),
        .wren       (wren),
        .ram_out    (ram_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready)
`ifdef RAM_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    always @(posedge clk) ram_out <= mem[address];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   total_hs = 0;
    int   last_hs = 0;
    int   max_level = 0;
    bit   bp_en = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer ready: held high, or the repeating pattern 1,0,0,1 under backpressure.
    always @(posedge clk) begin
        logic [3:0] pat;
        int         idx;
        pat = 4'b1001;
        #1;
        if (bp_en) begin
            data_ready = pat[3 - (idx % 4)];
            idx++;
        end else begin
            data_ready = 1'b1;
            idx = 0;
        end
    end

    // Monitor: compare every handshake against the scoreboard and check stall stability.
    always @(negedge clk) begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", data_valid, 1'b1);
                check("stall_data", data_out, prev_data);
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", data_out, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("data", data_out, exp_b);
                end
                check("wren", wren, 1'b0);
                total_hs++;
                last_hs = cyc;
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data_out;
            if (int'(dut.u_fifo.level) > max_level) max_level = int'(dut.u_fifo.level);
        end else begin
            prev_stall = 1'b0;
        end
    end

    int acc_cyc;
    int hs_base;

    task automatic raise_job(input logic [7:0] b, input logic [8:0] n);
        logic [7:0] a;
        a = b;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(a);
            a = a + 8'd1;
        end
        base_addr = b;
        count     = n;
        start     = 1'b1;
        acc_cyc   = cyc;
        hs_base   = total_hs;
    endtask

    task automatic start_job(input logic [7:0] b, input logic [8:0] n);
        @(posedge clk); #1;
        raise_job(b, n);
    endtask

    task automatic finish_job(input logic [8:0] n, input bit chk_cycles, input logic [7:0] cs);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!finished && k < 3000);
        check("finish_seen", finished, 1'b1);
        check("delivered", total_hs - hs_base, n);
        check("queue_empty", exp_q.size(), 0);
        check("valid_at_finish", data_valid, 1'b0);
        check("wren_at_finish", wren, 1'b0);
        if (n != 0) check("fin_after_last", cyc - last_hs, 1);
        if (chk_cycles) check("job_cycles", cyc - acc_cyc, (n == 0) ? 1 : int'(n) + LAT + 2);
`ifdef RAM_READER_CHECKSUM_EN
        check("checksum", checksum, cs);
`else
        if (cs !== cs) $display("unreachable");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("fin_hold", finished, 1'b1);
        @(negedge clk);
        check("fin_drop", finished, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_finished", finished, 1'b0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_wren", wren, 1'b0);
        check("rst_address", address, 8'h00);
        check("rst_data", data_out, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic job: addresses on consecutive cycles after acceptance.
        start_job(8'h10, 9'd4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("address_seq", address, 8'h10 + 8'(i));
        end
        finish_job(9'd4, 1'b1, 8'h00);

        // Address wrap.
        start_job(8'hFE, 9'd4);
        finish_job(9'd4, 1'b1, 8'h00);

        // Backpressure.
        bp_en = 1'b1;
        start_job(8'h40, 9'd8);
        finish_job(9'd8, 1'b0, 8'h00);
        bp_en = 1'b0;
        @(posedge clk);

        // Abort after 50 handshakes, restart after a single low cycle.
        start_job(8'h20, 9'd200);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while ((total_hs - hs_base) < 50 && k < 2000);
        check("abort_reach50", (total_hs - hs_base) >= 50, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("abort_valid", data_valid, 1'b0);
        check("abort_finished", finished, 1'b0);
        raise_job(8'h80, 9'd5);
        finish_job(9'd5, 1'b1, 8'h84);

        // Zero-length job.
        start_job(8'h33, 9'd0);
        finish_job(9'd0, 1'b1, 8'h00);

        // Checksum jobs.
        start_job(8'h00, 9'd4);
        finish_job(9'd4, 1'b1, 8'h00);
        start_job(8'h01, 9'd2);
        finish_job(9'd2, 1'b1, 8'h03);

        // Full memory.
        start_job(8'h05, 9'd256);
        finish_job(9'd256, 1'b1, 8'h00);

        check("fifo_bound", max_level <= DEPTH, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
